// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin front end that lets two requesters share one
// N-bit adder/subtractor, one operation at a time, with registered results
// returned over a per-requester valid/ready response channel.

// Plain combinational adder/subtractor; add_n_i = 1 selects x - y.
module adder_subtractor #(
    parameter int N = 4
) (
    input  logic [N-1:0] x_i,
    input  logic [N-1:0] y_i,
    input  logic         add_n_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o,
    output logic         ovf_o
);

    logic [N-1:0] yEff;
    logic [N:0]   fullSum;

    // Subtraction is x + ~y + 1; overflow when like-signed operands give an opposite-signed sum
    always_comb begin
        yEff    = y_i ^ {N{add_n_i}};
        fullSum = {1'b0, x_i} + {1'b0, yEff} + {{N{1'b0}}, add_n_i};
        sum_o   = fullSum[N-1:0];
        cout_o  = fullSum[N];
        ovf_o   = (x_i[N-1] & yEff[N-1] & ~fullSum[N-1]) |
                  (~x_i[N-1] & ~yEff[N-1] & fullSum[N-1]);
    end

endmodule

module addsub_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [N-1:0] req_x0,
    input  logic [N-1:0] req_y0,
    input  logic [N-1:0] req_x1,
    input  logic [N-1:0] req_y1,
    input  logic [1:0]   req_sub,
    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ready,
    output logic [N-1:0] rsp_sum,
    output logic         rsp_cout,
    output logic         rsp_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state_q;
    logic         ptr_q;
    logic         gntId_q;
    logic [N-1:0] x_q;
    logic [N-1:0] y_q;
    logic         sub_q;
    logic [N-1:0] rspSum_q;
    logic         rspCout_q;
    logic         rspOvf_q;
    logic [1:0]   rspValid_q;

    logic         grantValid;
    logic         gntId_d;
    logic [N-1:0] x_d;
    logic [N-1:0] y_d;
    logic         sub_d;

    logic [N-1:0] addSum;
    logic         addCout;
    logic         addOvf;

    // Grant decision: only in IDLE and out of reset; ptr breaks ties, never rsp_ready
    always_comb begin
        grantValid = 1'b0;
        gntId_d    = 1'b0;
        req_ready  = 2'b00;
        if (!rst && state_q == IDLE) begin
            case (req_valid)
                2'b01: begin
                    grantValid = 1'b1;
                    gntId_d    = 1'b0;
                end
                2'b10: begin
                    grantValid = 1'b1;
                    gntId_d    = 1'b1;
                end
                2'b11: begin
                    grantValid = 1'b1;
                    gntId_d    = ptr_q;
                end
                default: begin
                    grantValid = 1'b0;
                    gntId_d    = 1'b0;
                end
            endcase
            if (grantValid) begin
                req_ready = gntId_d ? 2'b10 : 2'b01;
            end
        end
        x_d   = gntId_d ? req_x1 : req_x0;
        y_d   = gntId_d ? req_y1 : req_y0;
        sub_d = req_sub[gntId_d];
    end

    // The shared datapath sees only captured operands, never the live request ports
    adder_subtractor #(.N(N)) u_addsub (
        .x_i     (x_q),
        .y_i     (y_q),
        .add_n_i (sub_q),
        .sum_o   (addSum),
        .cout_o  (addCout),
        .ovf_o   (addOvf)
    );

    // Sequencer: capture in IDLE, register the result in EXEC, hold it in RESP until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            gntId_q    <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            sub_q      <= 1'b0;
            rspSum_q   <= '0;
            rspCout_q  <= 1'b0;
            rspOvf_q   <= 1'b0;
            rspValid_q <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grantValid) begin
                        x_q     <= x_d;
                        y_q     <= y_d;
                        sub_q   <= sub_d;
                        gntId_q <= gntId_d;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    rspSum_q   <= addSum;
                    rspCout_q  <= addCout;
                    rspOvf_q   <= addOvf;
                    rspValid_q <= gntId_q ? 2'b10 : 2'b01;
                    state_q    <= RESP;
                end
                RESP: begin
                    if (rsp_ready[gntId_q]) begin
                        rspValid_q <= 2'b00;
                        ptr_q      <= ~gntId_q;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rspValid_q;
    assign rsp_sum   = rspSum_q;
    assign rsp_cout  = rspCout_q;
    assign rsp_ovf   = rspOvf_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: directed bench with a scoreboard of expected responses
// computed from signed/unsigned integer arithmetic.
module tb_addsub_arbiter;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [N-1:0] req_x0, req_y0, req_x1, req_y1;
    logic [1:0]   req_sub;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [N-1:0] rsp_sum;
    logic         rsp_cout;
    logic         rsp_ovf;

    typedef struct {
        int           id;
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    addsub_arbiter #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x0    (req_x0),
        .req_y0    (req_y0),
        .req_x1    (req_x1),
        .req_y1    (req_y1),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result from integer arithmetic on the interpreted operands
    function automatic exp_t model(int id, logic [N-1:0] x, logic [N-1:0] y, logic sub);
        exp_t e;
        int   sx, sy, r;
        sx = int'($signed(x));
        sy = int'($signed(y));
        r  = sub ? (sx - sy) : (sx + sy);
        e.id   = id;
        e.sum  = r[N-1:0];
        e.ovf  = (r > 7) || (r < -8);
        e.cout = sub ? (x >= y) : ((int'(x) + int'(y)) > 15);
        return e;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic setReq(int id, logic [N-1:0] x, logic [N-1:0] y, logic sub);
        if (id == 0) begin
            req_x0 = x;
            req_y0 = y;
        end else begin
            req_x1 = x;
            req_y1 = y;
        end
        req_sub[id] = sub;
    endtask

    // Issue one lone request from IDLE and walk it to its response cycle
    task automatic applyStimulus(int id, logic [N-1:0] x, logic [N-1:0] y, logic sub);
        setReq(id, x, y, sub);
        req_valid     = 2'b00;
        req_valid[id] = 1'b1;
        #1;
        check("grant_ready", 32'(req_ready), (id == 0) ? 32'h1 : 32'h2);
        sb.push_back(model(id, x, y, sub));
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check("exec_ready", 32'(req_ready), 32'h0);
        check("exec_rsp_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
    endtask

    // Compare the presented response against the oldest scoreboard entry
    task automatic checkOutput(bit popIt);
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 32'h0, 32'h1);
        end else begin
            e = sb[0];
            #1;
            check("rsp_valid", 32'(rsp_valid), (e.id == 0) ? 32'h1 : 32'h2);
            check("rsp_sum", 32'(rsp_sum), 32'(e.sum));
            check("rsp_cout", 32'(rsp_cout), 32'(e.cout));
            check("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
            if (popIt) void'(sb.pop_front());
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst       = 1'b1;
        req_valid = 2'b00;
        req_x0 = '0; req_y0 = '0; req_x1 = '0; req_y1 = '0;
        req_sub   = 2'b00;
        rsp_ready = 2'b11;

        // Reset state
        repeat (2) @(negedge clk);
        req_valid = 2'b11;
        #1;
        check("reset_req_ready", 32'(req_ready), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_sum", 32'(rsp_sum), 32'h0);
        check("reset_rsp_cout", 32'(rsp_cout), 32'h0);
        check("reset_rsp_ovf", 32'(rsp_ovf), 32'h0);
        req_valid = 2'b00;
        rst = 1'b0;

        // Single operations: add with overflow, subtracts with and without borrow
        applyStimulus(0, 4'd7, 4'd1, 1'b0);
        checkOutput(1'b1);
        @(negedge clk);
        applyStimulus(1, 4'd5, 4'd3, 1'b1);
        checkOutput(1'b1);
        @(negedge clk);
        applyStimulus(0, 4'd3, 4'd5, 1'b1);
        checkOutput(1'b1);
        @(negedge clk);
        applyStimulus(1, 4'd8, 4'd1, 1'b1);
        checkOutput(1'b1);
        @(negedge clk);

        // Contention from reset: grants must alternate 0,1,0,1
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        setReq(0, 4'd6, 4'd3, 1'b0);
        setReq(1, 4'd2, 4'd7, 1'b1);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_grant", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            if (k % 2 == 0) sb.push_back(model(0, 4'd6, 4'd3, 1'b0));
            else            sb.push_back(model(1, 4'd2, 4'd7, 1'b1));
            @(negedge clk);
            #1;
            check("rr_exec_ready", 32'(req_ready), 32'h0);
            @(negedge clk);
            check("rr_resp_ready", 32'(req_ready), 32'h0);
            checkOutput(1'b1);
            @(negedge clk);
        end
        req_valid = 2'b00;

        // Back-pressure: response held frozen for 5 cycles, no grants meanwhile
        rsp_ready = 2'b00;
        applyStimulus(0, 4'd4, 4'd4, 1'b0);
        setReq(1, 4'd1, 4'd1, 1'b0);
        req_valid = 2'b10;
        for (int k = 0; k < 5; k++) begin
            checkOutput(1'b0);
            check("bp_req_ready", 32'(req_ready), 32'h0);
            @(negedge clk);
        end
        rsp_ready = 2'b01;
        checkOutput(1'b1);
        @(negedge clk);
        #1;
        check("bp_idle_grant", 32'(req_ready), 32'h2);
        req_valid = 2'b00;
        #1;
        check("cancel_ready", 32'(req_ready), 32'h0);
        rsp_ready = 2'b11;

        // Reset during EXEC drops the operation and rewinds ptr to requester 0
        setReq(0, 4'd5, 4'd6, 1'b0);
        req_valid = 2'b01;
        #1;
        check("midrst_grant", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        check("midrst_req_ready", 32'(req_ready), 32'h0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("midrst_rsp_sum", 32'(rsp_sum), 32'h0);
        check("midrst_rsp_cout", 32'(rsp_cout), 32'h0);
        check("midrst_rsp_ovf", 32'(rsp_ovf), 32'h0);
        rst = 1'b0;
        setReq(0, 4'd2, 4'd3, 1'b1);
        setReq(1, 4'd9, 4'd9, 1'b0);
        #1;
        check("post_rst_grant", 32'(req_ready), 32'h1);
        sb.push_back(model(0, 4'd2, 4'd3, 1'b1));
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check("post_rst_exec_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        checkOutput(1'b1);
        @(negedge clk);
        #1;
        check("final_rsp_valid", 32'(rsp_valid), 32'h0);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Sequenced, two-requester front end for the shared N-bit adder_subtractor datapath. It accepts add/subtract commands from two independent requesters over valid/ready handshakes and arbitrates between them round-robin. It runs one operation at a time through a single internal adder_subtractor instance and returns the registered sum, carry and signed overflow to the requester that issued the command. It sits between control FSMs that need occasional arithmetic and the one add/sub unit they share.

## Interface

Parameters:
- N, default 4: operand/result width in bits; N ≥ 2.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- req_valid, input, 2: bit i means requester i presents a command.
- req_ready, output, 2: bit i means requester i's command is accepted this cycle.
- req_x0, req_y0, input, N each: requester 0 operands.
- req_x1, req_y1, input, N each: requester 1 operands.
- req_sub, input, 2: bit i selects the operation for requester i; 1 = x − y, 0 = x + y.
- rsp_valid, output, 2: bit i means the result for requester i is valid.
- rsp_ready, input, 2: bit i means requester i consumes its result.
- rsp_sum, output, N: result, x ± y mod 2^N.
- rsp_cout, output, 1: adder carry-out. For subtraction it is the no-borrow flag: 1 iff x ≥ y unsigned.
- rsp_ovf, output, 1: two's-complement signed overflow.

## Operation

- Internal adder_subtractor #(N). Its add_n input is driven from the captured sub bit. Its operands come only from the capture registers, never directly from the request ports.
- FSM states:
  - IDLE:
    - req_ready is nonzero only in IDLE.
    - If no req_valid bit is set, stay in IDLE.
    - If exactly one bit is set, grant that requester.
    - If both bits are set, grant the requester selected by the round-robin pointer ptr.
    - On grant: req_ready[g] = 1 combinationally in the same cycle. At the edge, capture x/y/sub of requester g and the id g, then go to EXEC.
  - EXEC:
    - Register the adder outputs (sum, cout, overflow) into the response registers, then go to RESP.
  - RESP:
    - Assert rsp_valid[g] only; the other bit stays 0.
    - rsp_sum, rsp_cout and rsp_ovf hold stable until rsp_ready[g] = 1.
    - On handshake, go to IDLE and set ptr = ~g.
    - rsp_ready of the non-granted requester is ignored.
- ptr updates only on a completed response handshake, so a lone requester may be served back-to-back.
- Handshake rules:
  - A requester must hold req_valid and its operands stable until req_ready is seen.
  - Dropping req_valid before acceptance is legal and cancels the request.
  - No request is accepted during EXEC or RESP, so at most one operation is outstanding.
- Arithmetic:
  - sum = x + (y XOR {N{sub}}) + sub, truncated to N bits.
  - cout is bit N of that addition.
  - ovf = (x[N−1] & y'[N−1] & ~sum[N−1]) | (~x[N−1] & ~y'[N−1] & sum[N−1]), where y' = y XOR {N{sub}}.
- Reset:
  - rst forces IDLE and sets ptr = 0.
  - Clears rsp_valid, rsp_sum, rsp_cout, rsp_ovf and the capture registers to 0.
  - An operation in EXEC or RESP when rst is sampled is discarded with no response.
  - req_ready = 0 while rst is high.

## Timing

- Reset values: req_ready = 2'b00, rsp_valid = 2'b00, rsp_sum = 0, rsp_cout = 0, rsp_ovf = 0.
- Request accepted at the edge ending cycle T (IDLE, valid & ready):
  - Cycle T+1 is EXEC.
  - rsp_valid is high from cycle T+2.
- Minimum turnaround: if rsp_ready is held high, the response completes in cycle T+2 and IDLE is in cycle T+3. This gives at most one operation per 3 cycles.
- Response outputs are registered. req_ready is combinational from req_valid, state and ptr only; it has no path from rsp_ready.
- Back-pressure: rsp_ready low holds the FSM in RESP indefinitely with outputs frozen.

## Test plan

- Reset, then a single add (N=4, requester 0, x=7, y=1, sub=0):
  - req_ready=01 in the request cycle.
  - Two cycles later: rsp_valid=01, sum=1000, cout=0, ovf=1.
- Subtract without borrow (requester 1, x=5, y=3, sub=1): rsp_valid=10, sum=0010, cout=1, ovf=0.
- Subtract with borrow and with signed overflow:
  - x=3, y=5, sub=1 → sum=1110, cout=0, ovf=0.
  - x=8, y=1, sub=1 → sum=0111, cout=1, ovf=1.
- Contention: both requesters valid continuously from reset.
  - Grant order is 0, 1, 0, 1.
  - Each response arrives 2 cycles after acceptance with correct per-requester results.
  - req_ready is never 11.
- Back-pressure: hold rsp_ready=0 for 5 cycles in RESP.
  - rsp_valid and the result stay constant.
  - No req_ready is asserted.
  - Releasing rsp_ready returns the FSM to IDLE in the next cycle.
- Reset mid-operation: assert rst in the EXEC cycle.
  - The next cycle shows all outputs 0 and no rsp_valid for the dropped operation.
  - A subsequent simultaneous request is granted to requester 0 (ptr reset).
